// File: rtl/joy_serializer.sv
// joy_serializer
//   Device end of the two-player joystick serial link. Emulates the
//   parallel-load shift-register chain the host polls with joy_load / joy_clk,
//   presenting 24 active-low button lines one bit at a time on joy_data.
//
// Ports
//   clk          system clock, at least 8x the joy_clk frequency
//   reset        synchronous, active-high
//   joy1, joy2   12-bit player buttons, active-low (1 = released)
//   joy_clk      host shift clock, asynchronous to clk
//   joy_load     host load strobe, active-low, asynchronous to clk
//   joy_data     registered serial data to the host
//   frame_done   one-clk pulse after the last button position is shifted past
//   frame_count  completed frames, wraps 255 -> 0
//
// States
//   IDLE  | no frame in progress, joy_data held at 1
//   LOAD  | joy_load low, shadow register tracks the buttons every clk
//   SHIFT | joy_load released, each joy_clk rise advances one position
//
// SYNC_STAGES is intended for the range 2..4.

module joy_serializer #(
  parameter int PAD_BITS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] joy1,
  input  logic [11:0] joy2,
  input  logic        joy_clk,
  input  logic        joy_load,
  output logic        joy_data,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int FRAME_LEN = PAD_BITS + 24;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_prev;
  logic                   load_prev;
  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;
  logic                   load_fall;
  logic                   load_rise;
  logic [23:0]            shadow;
  logic [23:0]            live_buttons;
  logic [FRAME_LEN:0]     shadow_frame;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;

  // Bit i of the packed word is frame position PAD_BITS+i.
  function automatic logic [23:0] pack_buttons(input logic [11:0] j1,
                                               input logic [11:0] j2);
    return {j1[7], j1[9], j1[11], j1[10],
            j2[7], j2[9], j2[11], j2[10],
            j2[0], j2[1], j2[2],  j2[3], j2[4], j2[5], j2[6], j2[8],
            j1[0], j1[1], j1[2],  j1[3], j1[4], j1[5], j1[6], j1[8]};
  endfunction

  // Synchronizers reset to the inactive level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      load_sync <= '1;
      clk_prev  <= 1'b1;
      load_prev <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
      clk_prev  <= clk_s;
      load_prev <= load_s;
    end
  end

  assign clk_s        = clk_sync[SYNC_STAGES-1];
  assign load_s       = load_sync[SYNC_STAGES-1];
  assign clk_rise     = clk_s & ~clk_prev;
  assign load_fall    = ~load_s & load_prev;
  assign load_rise    = load_s & ~load_prev;

  assign live_buttons = pack_buttons(joy1, joy2);
  // Top bit is the all-ones tail seen once the last position is passed.
  assign shadow_frame = {1'b1, shadow, {PAD_BITS{1'b1}}};
  assign cnt_next     = cnt + 1'b1;

  // Load edges take priority over a joy_clk edge detected in the same clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      joy_data    <= 1'b1;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
      shadow      <= '1;
      cnt         <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          joy_data <= 1'b1;
          if (load_fall) begin
            state  <= LOAD;
            cnt    <= '0;
            shadow <= live_buttons;
          end
        end

        LOAD: begin
          // joy_data trails the snapshot by one clk; release takes several
          // more clks to reach here, so position 0 is settled well before.
          joy_data <= shadow_frame[0];
          if (load_rise) begin
            state <= SHIFT;
          end else begin
            shadow <= live_buttons;
          end
        end

        SHIFT: begin
          if (load_fall) begin
            state    <= LOAD;
            cnt      <= '0;
            shadow   <= live_buttons;
            joy_data <= shadow_frame[0];
          end else if (clk_rise) begin
            cnt <= cnt_next;
            if (cnt_next == LAST_POS) begin
              state       <= IDLE;
              joy_data    <= 1'b1;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else begin
              joy_data <= shadow_frame[cnt_next];
            end
          end
        end

        default: begin
          state    <= IDLE;
          joy_data <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joy_serializer.sv
module tb_joy_serializer;

  logic        clk;
  logic        reset;
  logic [11:0] joy1;
  logic [11:0] joy2;
  logic        joy_clk;
  logic        joy_load;
  logic        joy_data;
  logic        frame_done;
  logic [7:0]  frame_count;

  int checks;
  int errors;

  // Frame model: source player and bit for each of the 24 button positions.
  localparam int SRC_P [24] = '{1, 1, 1, 1, 1, 1, 1, 1,
                                2, 2, 2, 2, 2, 2, 2, 2,
                                2, 2, 2, 2, 1, 1, 1, 1};
  localparam int SRC_B [24] = '{8, 6, 5, 4, 3, 2, 1, 0,
                                8, 6, 5, 4, 3, 2, 1, 0,
                                10, 11, 9, 7, 10, 11, 9, 7};

  logic        exp_q[$];
  logic        obs_q[$];
  int          pos_q[$];
  logic [11:0] frm_j1;
  logic [11:0] frm_j2;
  int          cur_pos;
  bit          in_frame;
  int          exp_count;
  int          exp_done;
  int          done_pulses;

  joy_serializer #(.PAD_BITS(2), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .joy1       (joy1),
    .joy2       (joy2),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_pulses++;

  function automatic logic model_bit(int pos, logic [11:0] j1, logic [11:0] j2);
    int k;
    if (pos < 2 || pos >= 26) return 1'b1;
    k = pos - 2;
    return (SRC_P[k] == 1) ? j1[SRC_B[k]] : j2[SRC_B[k]];
  endfunction

  task automatic do_load(input logic [11:0] j1, input logic [11:0] j2, input bit with_clk);
    joy1 = j1;
    joy2 = j2;
    joy_load = 1'b0;
    repeat (8) @(negedge clk);
    joy_load = 1'b1;
    if (with_clk) joy_clk = 1'b1;
    frm_j1 = j1;
    frm_j2 = j2;
    cur_pos = 0;
    in_frame = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(model_bit(0, frm_j1, frm_j2));
    obs_q.push_back(joy_data);
    pos_q.push_back(0);
    joy_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clk_edge();
    logic e;
    joy_clk = 1'b1;
    if (in_frame) begin
      cur_pos++;
      e = model_bit(cur_pos, frm_j1, frm_j2);
      if (cur_pos == 26) begin
        in_frame = 1'b0;
        exp_count = (exp_count + 1) % 256;
        exp_done++;
      end
    end else begin
      e = 1'b1;
    end
    repeat (4) @(negedge clk);
    exp_q.push_back(e);
    obs_q.push_back(joy_data);
    pos_q.push_back(in_frame ? cur_pos : -1);
    joy_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    in_frame = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int d0;
    d0 = done_pulses;
    repeat (20) @(negedge clk);
    checks++;
    if (joy_data !== 1'b1) begin
      errors++; $display("FAIL reset_data got %b want 1", joy_data);
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", frame_count);
    end
    checks++;
    if (done_pulses - d0 !== 0) begin
      errors++; $display("FAIL reset_done got %0d want 0", done_pulses - d0);
    end
  endtask

  task automatic test_single_press();
    int d0;
    d0 = done_pulses;
    do_load(12'hFFE, 12'hFFF, 1'b0);
    repeat (26) clk_edge();
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL single_press pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (done_pulses - d0 !== 1) begin
      errors++; $display("FAIL single_press_done got %0d want 1", done_pulses - d0);
    end
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++; $display("FAIL single_press_count got %0d want %0d", frame_count, exp_count);
    end
  endtask

  task automatic test_frozen_shadow();
    do_load(12'hFFF, 12'h7FF, 1'b0);
    repeat (10) clk_edge();
    joy2 = 12'hFFF;
    joy1 = 12'h000;
    repeat (16) clk_edge();
    joy1 = 12'hFFF;
    do_load(12'hFFF, 12'hFFF, 1'b0);
    repeat (26) clk_edge();
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL frozen_shadow pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++; $display("FAIL frozen_count got %0d want %0d", frame_count, exp_count);
    end
  endtask

  task automatic test_abort();
    int d0;
    logic [7:0] c0;
    d0 = done_pulses;
    c0 = frame_count;
    do_load(12'h5A5, 12'hA5A, 1'b0);
    repeat (10) clk_edge();
    do_load(12'h3C6, 12'h9E1, 1'b0);
    checks++;
    if (done_pulses - d0 !== 0 || frame_count !== c0) begin
      errors++;
      $display("FAIL abort_no_done got done %0d count %0d want done 0 count %0d",
               done_pulses - d0, frame_count, c0);
    end
    repeat (26) clk_edge();
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL abort pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (frame_count !== c0 + 8'd1 || done_pulses - d0 !== 1) begin
      errors++;
      $display("FAIL abort_complete got count %0d done %0d want count %0d done 1",
               frame_count, done_pulses - d0, c0 + 8'd1);
    end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_pulses;
    do_load(12'hBFF, 12'hFFB, 1'b0);
    repeat (30) clk_edge();
    repeat (5) clk_edge();
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL overrun pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (done_pulses - d0 !== 1) begin
      errors++; $display("FAIL overrun_done got %0d want 1", done_pulses - d0);
    end
  endtask

  task automatic test_same_edge();
    int d0;
    d0 = done_pulses;
    do_load(12'h000, 12'h000, 1'b1);
    repeat (25) clk_edge();
    checks++;
    if (done_pulses - d0 !== 0) begin
      errors++; $display("FAIL same_edge_early got %0d want 0", done_pulses - d0);
    end
    clk_edge();
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL same_edge pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (done_pulses - d0 !== 1) begin
      errors++; $display("FAIL same_edge_done got %0d want 1", done_pulses - d0);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int f = 0; f < 256; f++) begin
      do_load(12'($urandom), 12'($urandom), 1'b0);
      repeat (26) clk_edge();
      if (f == 254) begin
        checks++;
        if (frame_count !== 8'd255) begin
          errors++; $display("FAIL wrap_255 got %0d want 255", frame_count);
        end
      end
    end
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL wrap_data pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (frame_count !== 8'(exp_count) || exp_count != 0) begin
      errors++; $display("FAIL wrap_0 got %0d want 0", frame_count);
    end
  endtask

  task automatic test_reset_mid();
    do_load(12'hFFF, 12'hFFF, 1'b0);
    repeat (26) clk_edge();
    do_load(12'h000, 12'h000, 1'b0);
    repeat (5) clk_edge();
    checks++;
    if (joy_data !== 1'b0 || frame_count !== 8'd1) begin
      errors++; $display("FAIL reset_mid_pre got data %b count %0d want 0 1", joy_data, frame_count);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (joy_data !== 1'b1 || frame_count !== 8'd0) begin
      errors++; $display("FAIL reset_mid got data %b count %0d want 1 0", joy_data, frame_count);
    end
    reset = 1'b0;
    exp_count = 0;
    in_frame = 1'b0;
    exp_q.delete(); obs_q.delete(); pos_q.delete();
  endtask

  task automatic test_idle_clocks();
    int d0;
    d0 = done_pulses;
    repeat (6) clk_edge();
    while (exp_q.size() > 0) begin
      logic e, o; int p;
      e = exp_q.pop_front(); o = obs_q.pop_front(); p = pos_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL idle_clocks pos %0d got %b want %b", p, o, e);
      end
    end
    checks++;
    if (done_pulses - d0 !== 0 || frame_count !== 8'(exp_count)) begin
      errors++; $display("FAIL idle_clocks_done got done %0d count %0d want 0 %0d",
                         done_pulses - d0, frame_count, exp_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 0;
    exp_done = 0;
    done_pulses = 0;
    in_frame = 1'b0;
    cur_pos = 0;
    frm_j1 = 12'hFFF;
    frm_j2 = 12'hFFF;
    reset = 1'b1;
    joy_clk = 1'b0;
    joy_load = 1'b1;
    joy1 = 12'hFFF;
    joy2 = 12'hFFF;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_press();
    test_frozen_shadow();
    test_abort();
    test_overrun();
    test_same_edge();
    test_idle_clocks();
    test_wrap();
    test_reset_mid();
    test_idle_clocks();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
